// File: rtl/ysyx_20020207_csr_seq.sv
// SYSTEM-opcode sequencer: decodes CSR/trap instructions, drives the CSR unit and returns a GPR/redirect result.
// Optional macro CSR_SEQ_SET_CLR_EN enables CSRRS/CSRRC and all immediate CSR forms.
module ysyx_20020207_csr_seq (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] inst_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] pc_i,
  output logic [11:0] csr_addr_o,
  output logic [2:0]  csr_ctrl_o,
  output logic        csr_decode_valid_o,
  output logic        csr_ctrl_valid_o,
  output logic        csr_wen_o,
  output logic [31:0] csr_wdata_o,
  output logic [31:0] csr_pc_o,
  input  logic [31:0] csr_rdata_i,
  input  logic [31:0] csr_upc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [4:0]  rd_addr_o,
  output logic        rd_wen_o,
  output logic [31:0] rd_wdata_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        ebreak_o,
  output logic        illegal_o
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_READ, S_WRITE, S_DONE} state_e;
  typedef enum logic [2:0] {OP_ILL, OP_ECALL, OP_EBREAK, OP_MRET, OP_CSR} op_e;

  function automatic op_e decode_op(input logic [31:0] inst);
    op_e op;
    op = OP_ILL;
    if (inst[6:0] == 7'b1110011) begin
      case (inst[14:12])
        3'b000: begin
          case (inst[31:20])
            12'h000: op = OP_ECALL;
            12'h001: op = OP_EBREAK;
            12'h302: op = OP_MRET;
            default: op = OP_ILL;
          endcase
        end
        3'b001: op = OP_CSR;
`ifdef CSR_SEQ_SET_CLR_EN
        3'b010, 3'b011, 3'b101, 3'b110, 3'b111: op = OP_CSR;
`endif
        default: op = OP_ILL;
      endcase
    end else begin
      op = OP_ILL;
    end
    return op;
  endfunction

  function automatic logic [2:0] ctrl_of(input op_e op);
    logic [2:0] c;
    case (op)
      OP_MRET:   c = 3'b001;
      OP_ECALL:  c = 3'b010;
      OP_EBREAK: c = 3'b011;
      OP_CSR:    c = 3'b100;
      default:   c = 3'b000;
    endcase
    return c;
  endfunction

  // Set/clear with a zero source leaves the CSR untouched, so no write is committed.
  function automatic logic csr_commit(input logic [31:0] inst, input op_e op);
    logic w;
    case (op)
      OP_ECALL: w = 1'b1;
      OP_CSR:   w = (inst[13:12] == 2'b01) || (inst[19:15] != 5'd0);
      default:  w = 1'b0;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] csr_new(input logic [31:0] inst, input logic [31:0] rs1,
                                          input logic [31:0] old);
    logic [31:0] src;
    logic [31:0] res;
    src = inst[14] ? {27'd0, inst[19:15]} : rs1;
    case (inst[13:12])
      2'b01:   res = src;
      2'b10:   res = old | src;
      2'b11:   res = old & ~src;
      default: res = src;
    endcase
    return res;
  endfunction

  state_e      state_q;
  logic [31:0] inst_q, rs1_q, pc_q, old_q, upc_q;
  logic        in_ready_q, dec_valid_q, ctrl_valid_q, csr_wen_q;
  logic [11:0] csr_addr_q;
  logic [2:0]  csr_ctrl_q;
  logic [31:0] csr_wdata_q, csr_pc_q, rd_wdata_q, redirect_pc_q;
  logic        out_valid_q, rd_wen_q, redirect_q, ebreak_q, illegal_q;
  logic [4:0]  rd_addr_q;

  op_e         cur_op;
  logic        csr_wen_d;
  logic [31:0] csr_wdata_d;

  assign cur_op = decode_op(inst_q);

  // Write-phase values derived from the latched instruction and the live CSR read data.
  always_comb begin
    csr_wen_d   = csr_commit(inst_q, cur_op);
    csr_wdata_d = 32'd0;
    if (cur_op == OP_CSR) begin
      csr_wdata_d = csr_new(inst_q, rs1_q, csr_rdata_i);
    end else begin
      csr_wdata_d = 32'd0;
    end
  end

  // Sequencer FSM; every output is registered and only asserted in its own state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      inst_q        <= 32'd0;
      rs1_q         <= 32'd0;
      pc_q          <= 32'd0;
      old_q         <= 32'd0;
      upc_q         <= 32'd0;
      in_ready_q    <= 1'b1;
      dec_valid_q   <= 1'b0;
      ctrl_valid_q  <= 1'b0;
      csr_addr_q    <= 12'd0;
      csr_ctrl_q    <= 3'd0;
      csr_wen_q     <= 1'b0;
      csr_wdata_q   <= 32'd0;
      csr_pc_q      <= 32'd0;
      out_valid_q   <= 1'b0;
      rd_addr_q     <= 5'd0;
      rd_wen_q      <= 1'b0;
      rd_wdata_q    <= 32'd0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'd0;
      ebreak_q      <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            inst_q       <= inst_i;
            rs1_q        <= rs1_data_i;
            pc_q         <= pc_i;
            in_ready_q   <= 1'b0;
            csr_addr_q   <= inst_i[31:20];
            csr_ctrl_q   <= ctrl_of(decode_op(inst_i));
            dec_valid_q  <= 1'b1;
            ctrl_valid_q <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          dec_valid_q  <= 1'b0;
          ctrl_valid_q <= 1'b0;
          csr_addr_q   <= 12'd0;
          csr_ctrl_q   <= 3'd0;
          state_q      <= S_READ;
        end
        S_READ: begin
          old_q       <= csr_rdata_i;
          upc_q       <= csr_upc_i;
          csr_wen_q   <= csr_wen_d;
          csr_wdata_q <= csr_wdata_d;
          csr_pc_q    <= pc_q;
          state_q     <= S_WRITE;
        end
        S_WRITE: begin
          csr_wen_q     <= 1'b0;
          csr_wdata_q   <= 32'd0;
          csr_pc_q      <= 32'd0;
          out_valid_q   <= 1'b1;
          rd_addr_q     <= (cur_op == OP_CSR) ? inst_q[11:7] : 5'd0;
          rd_wen_q      <= (cur_op == OP_CSR) && (inst_q[11:7] != 5'd0);
          rd_wdata_q    <= (cur_op == OP_CSR) ? old_q : 32'd0;
          redirect_q    <= (cur_op == OP_ECALL) || (cur_op == OP_MRET);
          redirect_pc_q <= ((cur_op == OP_ECALL) || (cur_op == OP_MRET)) ? upc_q : 32'd0;
          ebreak_q      <= (cur_op == OP_EBREAK);
          illegal_q     <= (cur_op == OP_ILL);
          state_q       <= S_DONE;
        end
        S_DONE: begin
          if (out_ready_i) begin
            out_valid_q   <= 1'b0;
            rd_addr_q     <= 5'd0;
            rd_wen_q      <= 1'b0;
            rd_wdata_q    <= 32'd0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'd0;
            ebreak_q      <= 1'b0;
            illegal_q     <= 1'b0;
            in_ready_q    <= 1'b1;
            state_q       <= S_IDLE;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready_o         = in_ready_q;
  assign csr_addr_o         = csr_addr_q;
  assign csr_ctrl_o         = csr_ctrl_q;
  assign csr_decode_valid_o = dec_valid_q;
  assign csr_ctrl_valid_o   = ctrl_valid_q;
  assign csr_wen_o          = csr_wen_q;
  assign csr_wdata_o        = csr_wdata_q;
  assign csr_pc_o           = csr_pc_q;
  assign out_valid_o        = out_valid_q;
  assign rd_addr_o          = rd_addr_q;
  assign rd_wen_o           = rd_wen_q;
  assign rd_wdata_o         = rd_wdata_q;
  assign redirect_o         = redirect_q;
  assign redirect_pc_o      = redirect_pc_q;
  assign ebreak_o           = ebreak_q;
  assign illegal_o          = illegal_q;

endmodule

// File: tb/tb_ysyx_20020207_csr_seq.sv
// Randomized bench for ysyx_20020207_csr_seq against a mnemonic-level reference model.
module tb_ysyx_20020207_csr_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] inst, rs1_data, pc;
  logic [11:0] csr_addr;
  logic [2:0]  csr_ctrl;
  logic        csr_decode_valid, csr_ctrl_valid, csr_wen;
  logic [31:0] csr_wdata, csr_pc, csr_rdata, csr_upc;
  logic        out_valid, out_ready;
  logic [4:0]  rd_addr;
  logic        rd_wen;
  logic [31:0] rd_wdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ebreak, illegal;

  always #5 clk = ~clk;

  ysyx_20020207_csr_seq dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .inst_i(inst), .rs1_data_i(rs1_data), .pc_i(pc),
    .csr_addr_o(csr_addr), .csr_ctrl_o(csr_ctrl),
    .csr_decode_valid_o(csr_decode_valid), .csr_ctrl_valid_o(csr_ctrl_valid),
    .csr_wen_o(csr_wen), .csr_wdata_o(csr_wdata), .csr_pc_o(csr_pc),
    .csr_rdata_i(csr_rdata), .csr_upc_i(csr_upc),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .rd_addr_o(rd_addr), .rd_wen_o(rd_wen), .rd_wdata_o(rd_wdata),
    .redirect_o(redirect), .redirect_pc_o(redirect_pc),
    .ebreak_o(ebreak), .illegal_o(illegal)
  );

  localparam int K_RW = 0, K_RS = 1, K_RC = 2, K_RWI = 3, K_RSI = 4, K_RCI = 5;
  localparam int K_ECALL = 6, K_EBREAK = 7, K_MRET = 8, K_ILL = 9;

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0]  e_ctrl;
  logic        e_is_csr, e_wen, e_rd_wen, e_redirect, e_ebreak, e_illegal;
  logic [31:0] e_wdata, e_rd_wdata, e_rpc;
  logic [4:0]  e_rd_addr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] encode(input int kind, input logic [11:0] csr,
                                         input logic [4:0] rs1f, input logic [4:0] rd);
    logic [31:0] r;
    logic [31:0] rnd;
    case (kind)
      K_RW:     r = {csr, rs1f, 3'd1, rd, 7'h73};
      K_RS:     r = {csr, rs1f, 3'd2, rd, 7'h73};
      K_RC:     r = {csr, rs1f, 3'd3, rd, 7'h73};
      K_RWI:    r = {csr, rs1f, 3'd5, rd, 7'h73};
      K_RSI:    r = {csr, rs1f, 3'd6, rd, 7'h73};
      K_RCI:    r = {csr, rs1f, 3'd7, rd, 7'h73};
      K_ECALL:  r = 32'h0000_0073;
      K_EBREAK: r = 32'h0010_0073;
      K_MRET:   r = 32'h3020_0073;
      default: begin
        rnd = $urandom;
        case (rnd[1:0])
          2'd0:    r = {csr, rs1f, 3'd4, rd, 7'h73};
          2'd1:    r = 32'h1050_0073;
          default: r = {rnd[31:7], 7'h33};
        endcase
      end
    endcase
    return r;
  endfunction

  // Reference behaviour expressed per mnemonic.
  task automatic model(input int kind, input logic [4:0] rs1f, input logic [4:0] rd,
                       input logic [31:0] rs1d, input logic [31:0] old, input logic [31:0] upc);
    bit set_clr, legal, imm;
    logic [31:0] src;
`ifdef CSR_SEQ_SET_CLR_EN
    set_clr = 1'b1;
`else
    set_clr = 1'b0;
`endif
    legal = (kind == K_RW) || (kind == K_ECALL) || (kind == K_EBREAK) || (kind == K_MRET) ||
            (set_clr && kind >= K_RS && kind <= K_RCI);
    e_ctrl = 3'd0; e_is_csr = 1'b0; e_wen = 1'b0; e_wdata = 32'd0;
    e_rd_addr = 5'd0; e_rd_wen = 1'b0; e_rd_wdata = 32'd0;
    e_redirect = 1'b0; e_rpc = 32'd0; e_ebreak = 1'b0; e_illegal = !legal;
    if (legal) begin
      if (kind == K_ECALL) begin
        e_ctrl = 3'd2; e_wen = 1'b1; e_redirect = 1'b1; e_rpc = upc;
      end else if (kind == K_MRET) begin
        e_ctrl = 3'd1; e_redirect = 1'b1; e_rpc = upc;
      end else if (kind == K_EBREAK) begin
        e_ctrl = 3'd3; e_ebreak = 1'b1;
      end else begin
        e_ctrl = 3'd4; e_is_csr = 1'b1;
        imm = (kind >= K_RWI);
        src = imm ? 32'(rs1f) : rs1d;
        if (kind == K_RW || kind == K_RWI) e_wdata = src;
        else if (kind == K_RS || kind == K_RSI) e_wdata = old | src;
        else e_wdata = old & ~src;
        e_wen = (kind == K_RW || kind == K_RWI) || (rs1f != 5'd0);
        e_rd_addr = rd; e_rd_wen = (rd != 5'd0); e_rd_wdata = old;
      end
    end
  endtask

  task automatic check_done(input string tag);
    check_eq({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, ".in_ready"}, 32'(in_ready), 32'd0);
    check_eq({tag, ".csr_wen"}, 32'(csr_wen), 32'd0);
    check_eq({tag, ".rd_wen"}, 32'(rd_wen), 32'(e_rd_wen));
    if (e_rd_wen) begin
      check_eq({tag, ".rd_addr"}, 32'(rd_addr), 32'(e_rd_addr));
      check_eq({tag, ".rd_wdata"}, rd_wdata, e_rd_wdata);
    end
    check_eq({tag, ".redirect"}, 32'(redirect), 32'(e_redirect));
    if (e_redirect) check_eq({tag, ".redirect_pc"}, redirect_pc, e_rpc);
    check_eq({tag, ".ebreak"}, 32'(ebreak), 32'(e_ebreak));
    check_eq({tag, ".illegal"}, 32'(illegal), 32'(e_illegal));
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
  task automatic run_txn(input string tag, input int kind, input logic [11:0] csr,
                         input logic [4:0] rs1f, input logic [4:0] rd, input logic [31:0] rs1d,
                         input logic [31:0] pcv, input logic [31:0] old, input logic [31:0] upc,
                         input int delay);
    model(kind, rs1f, rd, rs1d, old, upc);
    check_eq({tag, ".idle_ready"}, 32'(in_ready), 32'd1);
    inst = encode(kind, csr, rs1f, rd);
    rs1_data = rs1d; pc = pcv; csr_rdata = old; csr_upc = upc; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; inst = $urandom; rs1_data = $urandom; pc = $urandom;
    check_eq({tag, ".issue_ready"}, 32'(in_ready), 32'd0);
    check_eq({tag, ".decode_valid"}, 32'(csr_decode_valid), 32'd1);
    check_eq({tag, ".ctrl_valid"}, 32'(csr_ctrl_valid), 32'd1);
    check_eq({tag, ".csr_ctrl"}, 32'(csr_ctrl), 32'(e_ctrl));
    if (e_is_csr) check_eq({tag, ".csr_addr"}, 32'(csr_addr), 32'(csr));
    @(negedge clk);
    check_eq({tag, ".read_strobe"}, 32'(csr_decode_valid | csr_ctrl_valid), 32'd0);
    check_eq({tag, ".read_wen"}, 32'(csr_wen), 32'd0);
    check_eq({tag, ".read_out_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    csr_rdata = $urandom; csr_upc = $urandom;
    check_eq({tag, ".csr_wen"}, 32'(csr_wen), 32'(e_wen));
    if (e_wen && e_is_csr) check_eq({tag, ".csr_wdata"}, csr_wdata, e_wdata);
    if (e_wen) check_eq({tag, ".csr_pc"}, csr_pc, pcv);
    check_eq({tag, ".write_out_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check_done(tag);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check_done({tag, ".hold"});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, ".ret_idle"}, 32'(in_ready), 32'd1);
    check_eq({tag, ".ret_out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, ".ret_flags"}, 32'({rd_wen, redirect, ebreak, illegal}), 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    check_eq({tag, ".flags"}, 32'({csr_decode_valid, csr_ctrl_valid, csr_wen, out_valid,
                                  rd_wen, redirect, ebreak, illegal}), 32'd0);
    check_eq({tag, ".buses"}, 32'(csr_addr) | 32'(csr_ctrl) | csr_wdata | csr_pc |
                              32'(rd_addr) | rd_wdata | redirect_pc, 32'd0);
  endtask

  initial begin
    logic [31:0] r1, r2;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    inst = 32'd0; rs1_data = 32'd0; pc = 32'd0; csr_rdata = 32'd0; csr_upc = 32'd0;
    repeat (3) @(negedge clk);
    check_quiet("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("reset_released");

    run_txn("csrrw", K_RW, 12'h305, 5'd6, 5'd5, 32'h8000_0000, 32'h8000_0010, 32'h11, 32'h0, 0);
    run_txn("csrrs_x0", K_RS, 12'h300, 5'd0, 5'd0, 32'h1234_5678, 32'h8000_0020, 32'hAA, 32'h0, 0);
    run_txn("csrrc", K_RC, 12'h300, 5'd7, 5'd1, 32'h0F, 32'h8000_0030, 32'hFF, 32'h0, 1);
    run_txn("ecall", K_ECALL, 12'h000, 5'd0, 5'd0, 32'h0, 32'h8000_0100, 32'h5, 32'h8000_0400, 1);
    run_txn("mret", K_MRET, 12'h302, 5'd0, 5'd0, 32'h0, 32'h8000_0200, 32'h7, 32'h8000_0104, 3);
    run_txn("ebreak", K_EBREAK, 12'h001, 5'd0, 5'd0, 32'h0, 32'h8000_0300, 32'h9, 32'h8000_0500, 0);
    run_txn("csrrsi", K_RSI, 12'h341, 5'd3, 5'd2, 32'h0, 32'h8000_0400, 32'h30, 32'h0, 0);

    // Abort: reset lands while the sequencer is in READ.
    inst = encode(K_RW, 12'h305, 5'd6, 5'd5); rs1_data = 32'hDEAD_BEEF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort.csr_wen", 32'(csr_wen), 32'd0);
    check_eq("abort.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("abort.no_commit", 32'({csr_wen, out_valid}), 32'd0);
    end
    check_quiet("abort.quiet");

    for (int t = 0; t < 60; t++) begin
      r1 = $urandom; r2 = $urandom;
      run_txn("rand", int'($urandom_range(0, 9)), r1[11:0],
              (r1[13:12] == 2'd0) ? 5'd0 : r1[20:16],
              (r1[15:14] == 2'd0) ? 5'd0 : r1[25:21],
              (r2[0]) ? r2 : 32'(r1[31:26]), $urandom, $urandom, $urandom,
              int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ysyx_20020207_csr_seq.md
YSYX_20020207_CSR_SEQ -- requirements
Module: ysyx_20020207_csr_seq

Interface
REQ-001 clock  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 in_valid  input  1  IDU offers a SYSTEM-opcode instruction.
REQ-004 in_ready  output  1  sequencer can accept an instruction.
REQ-005 inst  input  32  raw instruction word.
REQ-006 rs1_data  input  32  register-file rs1 value.
REQ-007 pc  input  32  instruction PC.
REQ-008 csr_addr  output  12  CSR address to the CSR unit.
REQ-009 csr_ctrl  output  3  operation code: 000 none, 001 MRET, 010 ECALL, 011 EBREAK, 100 CSRW.
REQ-010 csr_decode_valid, csr_ctrl_valid  output  1 each  latch strobes for csr_addr/csr_ctrl.
REQ-011 csr_wen  output  1  CSR write-commit strobe.
REQ-012 csr_wdata, csr_pc  output  32 each  write data; PC for MEPC.
REQ-013 csr_rdata, csr_upc  input  32 each  CSR read value; trap/return target.
REQ-014 out_valid  output  1;  out_ready  input  1: result handshake to WBU.
REQ-015 rd_addr  output  5;  rd_wen  output  1;  rd_wdata  output  32: GPR writeback.
REQ-016 redirect  output  1;  redirect_pc  output  32: PC redirect to IFU.
REQ-017 ebreak  output  1;  illegal  output  1: halt and unsupported-instruction flags.

Function
REQ-018 FSM states IDLE, ISSUE, READ, WRITE, DONE; in_ready SHALL be 1 only in IDLE.
REQ-019 IDLE: in_valid=1 SHALL latch inst, rs1_data, pc and move to ISSUE; otherwise stay.
REQ-020 ISSUE (one cycle): drive csr_addr=inst[31:20] and decoded csr_ctrl; pulse csr_decode_valid and csr_ctrl_valid; go to READ.
REQ-021 READ (one cycle): capture csr_rdata and csr_upc into internal registers; compute csr_wdata; go to WRITE.
REQ-022 csr_wdata: CSRRW = src; CSRRS = old|src; CSRRC = old&~src; src = rs1_data (register forms) or zero-extended inst[19:15] (immediate forms); old = captured csr_rdata.
REQ-023 WRITE (one cycle): csr_wen=1 for ECALL and for CSR ops that write; csr_pc=latched pc; go to DONE.
REQ-024 CSRRS/CSRRC and their immediate forms with inst[19:15]=0 SHALL NOT write (csr_wen=0); CSRRW always writes.
REQ-025 DONE: out_valid=1 and all result outputs held stable until out_ready=1; on out_valid&&out_ready return to IDLE.
REQ-026 Latency: acceptance edge N -> out_valid high from cycle N+4; back-to-back throughput one instruction per 5 cycles minimum.
REQ-027 CSR ops: rd_wen=1 iff rd!=0; rd_wdata=old.
REQ-028 ECALL/MRET: redirect=1, redirect_pc=captured csr_upc; rd_wen=0.
REQ-029 EBREAK: ebreak=1; redirect=0; no CSR write.
REQ-030 Non-SYSTEM opcode or unsupported funct3/funct12: illegal=1; all write, redirect and ebreak outputs 0; the instruction still completes through DONE.
REQ-031 csr_wen, csr_*_valid, out_valid, rd_wen, redirect, ebreak and illegal SHALL be 0 outside their named states.

Reset
REQ-032 On reset low: state=IDLE, every output and internal register=0 except in_ready=1.
REQ-033 Reset mid-operation SHALL abort with no csr_wen pulse and no out_valid.

Configuration
REQ-034 Macro CSR_SEQ_SET_CLR_EN defined: CSRRS/CSRRC/CSRRWI/CSRRSI/CSRRCI supported per REQ-022.
REQ-035 Macro undefined: only CSRRW, ECALL, MRET, EBREAK supported; the other CSR forms SHALL be treated as illegal per REQ-030.

Verification
REQ-036 Reset held low, then released -> in_ready=1, all other outputs 0.
REQ-037 CSRRW x5,0x305,x6 with rs1_data=0x80000000, csr_rdata=0x11 -> csr_wen in WRITE with wdata=0x80000000; out_valid at N+4 with rd_addr=5, rd_wdata=0x11.
REQ-038 CSRRS x0,0x300,x0 -> csr_wen=0, rd_wen=0; CSRRC with rs1_data=0x0F, old=0xFF -> wdata=0xF0.
REQ-039 ECALL at pc=0x80000100, csr_upc=0x80000400 -> csr_ctrl=010, csr_pc=0x80000100, csr_wen=1, redirect_pc=0x80000400.
REQ-040 MRET with csr_upc=0x80000104 and out_ready held low for 3 cycles -> outputs stable, in_ready=0 throughout, IDLE one cycle after out_ready rises.
REQ-041 Reset asserted during READ -> no csr_wen pulse; without CSR_SEQ_SET_CLR_EN, CSRRSI -> illegal=1.
